hyperram_responder: RTL and testbench

//  HyperBus device-side responder: decodes CS#/CK/DQ/RWDS from a HyperRAM initiator and serves reads/writes

---
 rtl/hyperram_responder_pkg.sv | 41 ++++
 rtl/hyperram_responder_edge_sync.sv | 67 ++++++
 rtl/hyperram_responder.sv | 233 +++++++++++++++++++++++
 tb/tb_hyperram_responder.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hyperram_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hyperram_responder_pkg
// Purpose  : Shared definitions for the HyperBus responder: FSM state
//            encoding, command/address (CA) bit positions, register-space
//            word addresses and configuration-register reset values.
// Revision : 1.0 - initial release
// ============================================================================
package hyperram_responder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CA   = 3'd1,
        ST_LAT  = 3'd2,
        ST_WR   = 3'd3,
        ST_RD   = 3'd4
    } state_t;

    // CA word bit positions (CA[45] selects burst type; only linear is served)
    localparam int          c_ca_rw   = 47;
    localparam int          c_ca_as   = 46;
    localparam int          c_ca_bt   = 45;
    localparam logic [2:0]  c_ca_last = 3'd5;   // index of the sixth CA byte
    localparam logic [7:0]  c_ca_rises = 8'd3;  // CK rises consumed by CA

    // Register-space word addresses and values
    localparam logic [31:0] c_reg_id0 = 32'h0000_0000;
    localparam logic [31:0] c_reg_id1 = 32'h0000_0001;
    localparam logic [31:0] c_reg_cr0 = 32'h0000_0800;
    localparam logic [31:0] c_reg_cr1 = 32'h0000_0801;
    localparam logic [15:0] c_id1_val = 16'h0001;
    localparam logic [15:0] c_cr0_rst = 16'h8F1F;
    localparam logic [15:0] c_cr1_rst = 16'h0002;

    // Word address carried in the CA: row/upper column bits then lower column
    function automatic logic [31:0] ca_word_addr(input logic [47:0] ca);
        return {ca[44:16], ca[2:0]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/hyperram_responder_edge_sync.sv
`default_nettype none
// ============================================================================
// Module   : hyperram_responder_edge_sync
// Purpose  : Two-flop synchroniser for the HyperBus pins plus edge pulses.
//            CK, CS#, DQ and RWDS travel through identical flop chains so a
//            CK edge pulse and the DQ/RWDS value it qualifies stay aligned.
// Ports    : clk, rstn            - system clock, async active-low reset
//            i_ck/i_cs_l/i_dq/i_rwds - raw pad inputs
//            o_cs_l/o_dq/o_rwds   - synchronised levels
//            o_ck_rise/o_ck_fall  - one-clk pulses on synchronised CK edges
//            o_cs_start/o_cs_end  - one-clk pulses on CS# fall / rise
// Revision : 1.0 - initial release
// ============================================================================
module hyperram_responder_edge_sync (
    input  logic       clk,
    input  logic       rstn,
    input  logic       i_ck,
    input  logic       i_cs_l,
    input  logic [7:0] i_dq,
    input  logic       i_rwds,
    output logic       o_cs_l,
    output logic [7:0] o_dq,
    output logic       o_rwds,
    output logic       o_ck_rise,
    output logic       o_ck_fall,
    output logic       o_cs_start,
    output logic       o_cs_end
);

    logic [1:0] r_ck_sync;
    logic [1:0] r_cs_sync;
    logic [1:0] r_rwds_sync;
    logic [7:0] r_dq_meta;
    logic [7:0] r_dq_sync;
    logic       r_ck_d;
    logic       r_cs_d;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ck_sync   <= 2'b00;
            r_cs_sync   <= 2'b11;
            r_rwds_sync <= 2'b00;
            r_dq_meta   <= 8'h00;
            r_dq_sync   <= 8'h00;
            r_ck_d      <= 1'b0;
            r_cs_d      <= 1'b1;
        end else begin
            r_ck_sync   <= {r_ck_sync[0], i_ck};
            r_cs_sync   <= {r_cs_sync[0], i_cs_l};
            r_rwds_sync <= {r_rwds_sync[0], i_rwds};
            r_dq_meta   <= i_dq;
            r_dq_sync   <= r_dq_meta;
            r_ck_d      <= r_ck_sync[1];
            r_cs_d      <= r_cs_sync[1];
        end
    end

    assign o_cs_l     = r_cs_sync[1];
    assign o_dq       = r_dq_sync;
    assign o_rwds     = r_rwds_sync[1];
    assign o_ck_rise  =  r_ck_sync[1] & ~r_ck_d;
    assign o_ck_fall  = ~r_ck_sync[1] &  r_ck_d;
    assign o_cs_start = ~r_cs_sync[1] &  r_cs_d;
    assign o_cs_end   =  r_cs_sync[1] & ~r_cs_d;

endmodule
`default_nettype wire

// File: rtl/hyperram_responder.sv
`default_nettype none
// ============================================================================
// Module   : hyperram_responder
// Purpose  : HyperBus device-side responder serving reads/writes from an
//            on-chip 2**ADDR_W x 16 RAM. CK is oversampled in the clk domain
//            (CK half-period must be >= 4 clk).
// Ports    : clk, rstn          - system clock, async active-low reset
//            ck, cs_l           - HyperBus clock / chip select (active low)
//            dq_in/dq_out/dq_oe - DQ pad in, out, output enable
//            rwds_in/rwds_out/rwds_oe - RWDS pad in (write mask), out, enable
//            busy               - transaction open
//            proto_err          - one-clk pulse: CS# released during CA
// Config   : `define HRAM_RESP_REGS_EN makes the register space live
//            (ID0/ID1/CR0/CR1); otherwise register reads return zero and
//            register writes are consumed and dropped.
// Revision : 1.0 - initial release
// ============================================================================
module hyperram_responder
    import hyperram_responder_pkg::*;
#(
    parameter int          ADDR_W   = 10,
    parameter int          LATENCY  = 6,
    parameter int          FIXED_2X = 1,
    parameter logic [15:0] ID0_VAL  = 16'h0C81
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       ck,
    input  logic       cs_l,
    input  logic [7:0] dq_in,
    output logic [7:0] dq_out,
    output logic       dq_oe,
    input  logic       rwds_in,
    output logic       rwds_out,
    output logic       rwds_oe,
    output logic       busy,
    output logic       proto_err
);

    localparam logic c_fixed_2x = (FIXED_2X != 0);

    logic        w_cs_l, w_rwds, w_ck_rise, w_ck_fall, w_cs_start, w_cs_end;
    logic [7:0]  w_dq;

    hyperram_responder_edge_sync u_sync (
        .clk        (clk),
        .rstn       (rstn),
        .i_ck       (ck),
        .i_cs_l     (cs_l),
        .i_dq       (dq_in),
        .i_rwds     (rwds_in),
        .o_cs_l     (w_cs_l),
        .o_dq       (w_dq),
        .o_rwds     (w_rwds),
        .o_ck_rise  (w_ck_rise),
        .o_ck_fall  (w_ck_fall),
        .o_cs_start (w_cs_start),
        .o_cs_end   (w_cs_end)
    );

    state_t      r_state, w_state_nxt;
    logic        w_ca_take, w_data_rise, w_data_fall;
    logic [39:0] r_ca;
    logic [47:0] w_ca_next;
    logic [2:0]  r_byte_cnt;
    logic [7:0]  r_rise_cnt;     // index of the next CK rise (0 = CA byte0)
    logic [7:0]  w_target;       // rise index carrying the first data byte
    logic        r_is_read, r_is_reg;
    logic [31:0] r_addr;
    logic [7:0]  r_dq_drv, r_lo_hold, r_wr_hi;
    logic        r_rwds_drv, r_hi_en, r_proto_err;
    logic [15:0] r_mem [0:(1<<ADDR_W)-1];
    logic [15:0] r_ram_q, w_reg_rdata, w_rd_word;
    logic [ADDR_W-1:0] w_ram_addr;
    logic        w_double, w_mem_we, w_reg_we;
    logic [13:0] w_unused_ca;

    assign w_ca_next   = {r_ca, w_dq};
    assign w_unused_ca = {w_ca_next[c_ca_bt], w_ca_next[15:3]};
    assign w_ram_addr  = r_addr[ADDR_W-1:0];
    assign w_rd_word   = r_is_reg ? w_reg_rdata : r_ram_q;
    assign w_mem_we    = w_data_fall && (r_state == ST_WR) && !r_is_reg;
    assign w_reg_we    = w_data_fall && (r_state == ST_WR) &&  r_is_reg;

    // Register-space writes skip the latency; everything else waits N cycles
    assign w_target = (r_is_reg && !r_is_read) ? c_ca_rises
                    : c_ca_rises + (w_double ? 8'(2 * LATENCY) : 8'(LATENCY));

`ifdef HRAM_RESP_REGS_EN
    logic [15:0] r_cr0, r_cr1;

    assign w_double = c_fixed_2x || r_cr0[3];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cr0 <= c_cr0_rst;
            r_cr1 <= c_cr1_rst;
        end else if (w_reg_we) begin
            if (r_addr == c_reg_cr0) begin
                if (r_hi_en) r_cr0[15:8] <= r_wr_hi;
                if (!w_rwds) r_cr0[7:0]  <= w_dq;
            end
            if (r_addr == c_reg_cr1) begin
                if (r_hi_en) r_cr1[15:8] <= r_wr_hi;
                if (!w_rwds) r_cr1[7:0]  <= w_dq;
            end
        end
    end

    always_comb begin
        w_reg_rdata = 16'h0000;
        case (r_addr)
            c_reg_id0: w_reg_rdata = ID0_VAL;
            c_reg_id1: w_reg_rdata = c_id1_val;
            c_reg_cr0: w_reg_rdata = r_cr0;
            c_reg_cr1: w_reg_rdata = r_cr1;
            default:   w_reg_rdata = 16'h0000;
        endcase
    end
`else
    logic [191:0] w_unused_regs;

    assign w_double      = c_fixed_2x;
    assign w_reg_rdata   = 16'h0000;
    assign w_unused_regs = {ID0_VAL, c_id1_val, c_cr0_rst, c_cr1_rst, c_reg_id0,
                            c_reg_id1, c_reg_cr0, c_reg_cr1, w_reg_we,
                            r_addr[31:ADDR_W]};
`endif

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ca_take   = 1'b0;
        w_data_rise = 1'b0;
        w_data_fall = 1'b0;
        case (r_state)
            ST_IDLE: if (w_cs_start) w_state_nxt = ST_CA;
            // byte0 must land on a rise; later bytes take either edge
            ST_CA: if (w_ck_rise || (w_ck_fall && r_byte_cnt != 3'd0)) begin
                w_ca_take = 1'b1;
                if (r_byte_cnt == c_ca_last) w_state_nxt = ST_LAT;
            end
            ST_LAT: if (w_ck_rise && r_rise_cnt == w_target) begin
                w_data_rise = 1'b1;
                w_state_nxt = r_is_read ? ST_RD : ST_WR;
            end
            ST_WR, ST_RD: begin
                w_data_rise = w_ck_rise;
                w_data_fall = w_ck_fall;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        // CS# release aborts whatever is in flight, including a half word
        if (w_cs_l) begin
            w_state_nxt = ST_IDLE;
            w_ca_take   = 1'b0;
            w_data_rise = 1'b0;
            w_data_fall = 1'b0;
        end
    end

    // ----------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ca        <= '0;
            r_byte_cnt  <= 3'd0;
            r_rise_cnt  <= 8'd0;
            r_is_read   <= 1'b0;
            r_is_reg    <= 1'b0;
            r_addr      <= 32'd0;
            r_dq_drv    <= 8'h00;
            r_lo_hold   <= 8'h00;
            r_rwds_drv  <= 1'b0;
            r_wr_hi     <= 8'h00;
            r_hi_en     <= 1'b0;
            r_proto_err <= 1'b0;
        end else begin
            r_proto_err <= (r_state == ST_CA) && w_cs_end;
            if (r_state == ST_IDLE) begin
                r_byte_cnt <= 3'd0;
                r_rise_cnt <= 8'd0;
            end
            if ((r_state == ST_CA || r_state == ST_LAT) && w_ck_rise)
                r_rise_cnt <= r_rise_cnt + 8'd1;
            if (w_ca_take) begin
                r_ca       <= w_ca_next[39:0];
                r_byte_cnt <= r_byte_cnt + 3'd1;
                if (r_byte_cnt == c_ca_last) begin
                    r_is_read <= w_ca_next[c_ca_rw];
                    r_is_reg  <= w_ca_next[c_ca_as];
                    r_addr    <= ca_word_addr(w_ca_next);
                end
            end
            // Rise: present upper read byte / latch upper write byte
            if (w_data_rise) begin
                r_dq_drv   <= w_rd_word[15:8];
                r_lo_hold  <= w_rd_word[7:0];
                r_rwds_drv <= 1'b1;
                r_wr_hi    <= w_dq;
                r_hi_en    <= !w_rwds;
            end
            // Fall: lower byte completes the word; RAM prefetches addr+1
            if (w_data_fall) begin
                r_dq_drv   <= r_lo_hold;
                r_rwds_drv <= 1'b0;
                r_addr     <= r_addr + 32'd1;
            end
        end
    end

    // RAM: contents survive reset; read data is one clk behind the address
    always_ff @(posedge clk) begin
        if (w_mem_we && r_hi_en) r_mem[w_ram_addr][15:8] <= r_wr_hi;
        if (w_mem_we && !w_rwds) r_mem[w_ram_addr][7:0]  <= w_dq;
        r_ram_q <= r_mem[w_ram_addr];
    end

    // ------------------------------------------------------------ outputs
    assign busy      = (r_state != ST_IDLE);
    assign dq_oe     = (r_state == ST_RD) && !w_cs_l;
    assign rwds_oe   = ((r_state == ST_CA) || (r_state == ST_RD)) && !w_cs_l;
    assign dq_out    = (r_state == ST_RD) ? r_dq_drv : 8'h00;
    assign rwds_out  = (r_state == ST_CA) ? c_fixed_2x
                     : (r_state == ST_RD) ? r_rwds_drv : 1'b0;
    assign proto_err = r_proto_err;

endmodule
`default_nettype wire

// File: tb/tb_hyperram_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_hyperram_responder
// Purpose  : Self-checking bench for hyperram_responder. Acts as a HyperBus
//            initiator; read data is compared against a scoreboard queue of
//            expected words filled when the stimulus is issued.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_hyperram_responder;

    localparam int ADDR_W     = 10;
    localparam int LATENCY    = 6;
    localparam int FIXED_2X   = 1;
    localparam int HALF       = 4;    // clk cycles from data setup to CK edge
    localparam int FIRST_RISE = 15;   // 3 + LATENCY*2
    localparam int LAT_CYC    = FIRST_RISE - 3;
    localparam logic [31:0] LAST_ADDR = 32'd1023;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       ck = 1'b0;
    logic       cs_l = 1'b1;
    logic [7:0] dq_in = 8'h00;
    logic       rwds_in = 1'b0;
    logic [7:0] dq_out;
    logic       dq_oe, rwds_out, rwds_oe, busy, proto_err;

    int n_tests = 0;
    int n_fail  = 0;
    int n_perr  = 0;

    logic [15:0] q_exp[$];
    logic [15:0] q_got[$];
    logic [15:0] q_wd[$];
    logic [1:0]  q_wm[$];

    hyperram_responder #(
        .ADDR_W   (ADDR_W),
        .LATENCY  (LATENCY),
        .FIXED_2X (FIXED_2X),
        .ID0_VAL  (16'h0C81)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .ck        (ck),
        .cs_l      (cs_l),
        .dq_in     (dq_in),
        .dq_out    (dq_out),
        .dq_oe     (dq_oe),
        .rwds_in   (rwds_in),
        .rwds_out  (rwds_out),
        .rwds_oe   (rwds_oe),
        .busy      (busy),
        .proto_err (proto_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (proto_err === 1'b1) n_perr <= n_perr + 1;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------ drivers
    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic half_ck(input logic [7:0] b, input logic m);
        dq_in = b;
        rwds_in = m;
        wait_clk(HALF);
        ck = ~ck;
        wait_clk(HALF);
    endtask

    task automatic send_ca(input bit rd, input bit as, input logic [31:0] a,
                           input int nbytes, output bit rwds_ok);
        logic [47:0] ca;
        ca = {rd, as, 1'b0, a[31:3], 13'd0, a[2:0]};
        rwds_ok = 1'b1;
        cs_l = 1'b0;
        wait_clk(HALF);
        for (int i = 0; i < nbytes; i++) begin
            half_ck(ca[47-8*i -: 8], 1'b0);
            if (i < 5 && !(rwds_oe === 1'b1 && rwds_out === 1'b1)) rwds_ok = 1'b0;
        end
    endtask

    task automatic end_txn();
        cs_l = 1'b1;
        ck = 1'b0;
        dq_in = 8'h00;
        rwds_in = 1'b0;
        wait_clk(8);
    endtask

    task automatic do_write(input logic [31:0] a, input bit as, input int lat_cyc);
        bit          ok;
        int          n;
        logic [15:0] w;
        logic [1:0]  m;
        n = q_wd.size();
        send_ca(1'b0, as, a, 6, ok);
        repeat (2 * lat_cyc) half_ck(8'h00, 1'b0);
        for (int i = 0; i < n; i++) begin
            w = q_wd.pop_front();
            m = q_wm.pop_front();
            half_ck(w[15:8], m[1]);
            half_ck(w[7:0], m[0]);
        end
        end_txn();
    endtask

    task automatic do_read(input logic [31:0] a, input bit as, input int nw,
                           output bit ca_ok, output bit early, output bit strobe_ok);
        logic [7:0] hi, lo;
        early = 1'b0;
        strobe_ok = 1'b1;
        send_ca(1'b1, as, a, 6, ca_ok);
        for (int i = 0; i < 2 * LAT_CYC; i++) begin
            half_ck(8'h00, 1'b0);
            if (dq_oe !== 1'b0) early = 1'b1;
        end
        for (int i = 0; i < nw; i++) begin
            half_ck(8'h00, 1'b0);
            hi = dq_out;
            if (!(rwds_out === 1'b1 && dq_oe === 1'b1 && rwds_oe === 1'b1)) strobe_ok = 1'b0;
            half_ck(8'h00, 1'b0);
            lo = dq_out;
            if (!(rwds_out === 1'b0 && dq_oe === 1'b1 && rwds_oe === 1'b1)) strobe_ok = 1'b0;
            q_got.push_back({hi, lo});
        end
        end_txn();
    endtask

    // -------------------------------------------------------------- tests
    task automatic test_reset();
        rstn = 1'b0;
        wait_clk(3);
        n_tests++;
        if ({dq_out, dq_oe, rwds_out, rwds_oe, busy, proto_err} !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected %b",
                     {dq_out, dq_oe, rwds_out, rwds_oe, busy, proto_err}, 13'd0);
        end
        rstn = 1'b1;
        wait_clk(4);
        n_tests++;
        if ({dq_oe, rwds_oe, busy, proto_err} !== 4'd0) begin
            n_fail++;
            $display("FAIL post_reset_idle: got %b expected 0000", {dq_oe, rwds_oe, busy, proto_err});
        end
    endtask

    task automatic test_write_mask();
        bit ca_ok, early, strobe_ok;
        logic [15:0] got, exp;
        q_wd = '{16'h0000, 16'hBEEF}; q_wm = '{2'b00, 2'b00};
        do_write(32'h10, 1'b0, LAT_CYC);
        q_wd = '{16'hA5A5, 16'h1234}; q_wm = '{2'b00, 2'b10};
        do_write(32'h10, 1'b0, LAT_CYC);
        q_exp.push_back(16'hA5A5);
        q_exp.push_back(16'hBE34);
        do_read(32'h10, 1'b0, 2, ca_ok, early, strobe_ok);
        while (q_got.size() > 0) begin
            got = q_got.pop_front();
            exp = q_exp.pop_front();
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL write_mask_data: got %h expected %h", got, exp);
            end
        end
        n_tests++;
        if (strobe_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL write_mask_strobe: got %b expected 1", strobe_ok);
        end
    endtask

    task automatic test_latency();
        bit ca_ok, early, strobe_ok;
        logic [15:0] got, exp;
        q_exp.push_back(16'hA5A5);
        do_read(32'h10, 1'b0, 1, ca_ok, early, strobe_ok);
        n_tests++;
        if (ca_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL ca_rwds_high: got %b expected 1", ca_ok);
        end
        n_tests++;
        if (early !== 1'b0) begin
            n_fail++;
            $display("FAIL dq_oe_before_rise15: got %b expected 0", early);
        end
        n_tests++;
        if (strobe_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL rd_strobe_at_rise15: got %b expected 1", strobe_ok);
        end
        while (q_got.size() > 0) begin
            got = q_got.pop_front();
            exp = q_exp.pop_front();
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL latency_data: got %h expected %h", got, exp);
            end
        end
    endtask

    task automatic test_wrap();
        bit ca_ok, early, strobe_ok;
        logic [15:0] got, exp;
        q_wd = '{16'hC0DE, 16'hF00D}; q_wm = '{2'b00, 2'b00};
        do_write(LAST_ADDR, 1'b0, LAT_CYC);
        q_exp.push_back(16'hC0DE);
        q_exp.push_back(16'hF00D);
        do_read(LAST_ADDR, 1'b0, 2, ca_ok, early, strobe_ok);
        q_exp.push_back(16'hF00D);
        do_read(32'h0, 1'b0, 1, ca_ok, early, strobe_ok);
        while (q_got.size() > 0) begin
            got = q_got.pop_front();
            exp = q_exp.pop_front();
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL wrap_data: got %h expected %h", got, exp);
            end
        end
    endtask

    task automatic test_proto_err();
        bit ca_ok, early, strobe_ok;
        int base;
        logic [15:0] got, exp;
        base = n_perr;
        send_ca(1'b0, 1'b0, 32'h10, 4, ca_ok);
        end_txn();
        n_tests++;
        if (n_perr - base !== 1) begin
            n_fail++;
            $display("FAIL proto_err_pulse: got %0d cycles expected 1", n_perr - base);
        end
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL proto_err_busy: got %b expected 0", busy);
        end
        q_exp.push_back(16'hA5A5);
        do_read(32'h10, 1'b0, 1, ca_ok, early, strobe_ok);
        while (q_got.size() > 0) begin
            got = q_got.pop_front();
            exp = q_exp.pop_front();
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL proto_err_ram: got %h expected %h", got, exp);
            end
        end
    endtask

    task automatic test_reset_mid_read();
        bit ca_ok, early, strobe_ok;
        logic [15:0] got, exp;
        send_ca(1'b1, 1'b0, 32'h10, 6, ca_ok);
        repeat (2 * LAT_CYC) half_ck(8'h00, 1'b0);
        half_ck(8'h00, 1'b0);
        n_tests++;
        if (dq_oe !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_read_oe: got %b expected 1", dq_oe);
        end
        rstn = 1'b0;
        #1;
        n_tests++;
        if ({dq_oe, rwds_oe, busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_mid_read: got %b expected 000", {dq_oe, rwds_oe, busy});
        end
        end_txn();
        rstn = 1'b1;
        wait_clk(4);
        q_exp.push_back(16'hA5A5);
        do_read(32'h10, 1'b0, 1, ca_ok, early, strobe_ok);
        while (q_got.size() > 0) begin
            got = q_got.pop_front();
            exp = q_exp.pop_front();
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL after_reset_read: got %h expected %h", got, exp);
            end
        end
    endtask

    task automatic test_registers();
        bit ca_ok, early, strobe_ok;
        logic [15:0] got, exp;
`ifdef HRAM_RESP_REGS_EN
        q_exp.push_back(16'h0C81);
`else
        q_exp.push_back(16'h0000);
`endif
        do_read(32'h0, 1'b1, 1, ca_ok, early, strobe_ok);
        q_wd = '{16'h8E1C}; q_wm = '{2'b00};
        do_write(32'h800, 1'b1, 0);
`ifdef HRAM_RESP_REGS_EN
        q_exp.push_back(16'h8E1C);
`else
        q_exp.push_back(16'h0000);
`endif
        do_read(32'h800, 1'b1, 1, ca_ok, early, strobe_ok);
        // register write must not alias onto RAM word 0
        q_exp.push_back(16'hF00D);
        do_read(32'h0, 1'b0, 1, ca_ok, early, strobe_ok);
        while (q_got.size() > 0) begin
            got = q_got.pop_front();
            exp = q_exp.pop_front();
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL register_data: got %h expected %h", got, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_mask();
        test_latency();
        test_wrap();
        test_proto_err();
        test_reset_mid_read();
        test_registers();
        n_tests++;
        if (n_perr !== 1) begin
            n_fail++;
            $display("FAIL proto_err_total: got %0d expected 1", n_perr);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
